// File: rtl/cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cam_ctrl
// Brief   : Sequencing controller for a DEPTH x WIDTH CAM. It arbitrates
//           round-robin between a write port (lowest free entry) and a
//           search port (registered, priority-encoded hit). Optional macro:
//           CAM_CTRL_MULTI_HIT_EN enables the multi-hit flag.
// Revision: 1.0 - initial release
// ============================================================================
module cam_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             srch_valid_i,
  output logic             srch_ready_o,
  input  logic [WIDTH-1:0] srch_key_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic [IDX_W-1:0] rsp_index_o,
  output logic             rsp_multi_o,
  input  logic             clear_i,
  output logic [DEPTH-1:0] cam_write_en_o,
  output logic [WIDTH-1:0] cam_data_o,
  output logic             cam_search_en_o,
  output logic [WIDTH-1:0] cam_key_o,
  input  logic [DEPTH-1:0] cam_match_i,
  output logic [IDX_W:0]   count_o,
  output logic             full_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SEARCH = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic c_PRIO_WR = 1'b0;
  localparam logic c_PRIO_SR = 1'b1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic [DEPTH-1:0] r_valid;
  logic [IDX_W:0]   r_count;
  logic [WIDTH-1:0] r_wr_data;
  logic [IDX_W-1:0] r_wr_row;
  logic [WIDTH-1:0] r_key;
  logic             r_rsp_hit;
  logic [IDX_W-1:0] r_rsp_index;

  logic             w_full;
  logic             w_wr_acc;
  logic             w_sr_acc;
  logic [IDX_W-1:0] w_free_row;
  logic [DEPTH-1:0] w_masked;
  logic [IDX_W-1:0] w_hit_idx;

  assign w_full   = (r_count == (IDX_W+1)'(DEPTH));
  assign w_masked = cam_match_i & r_valid;

  // Both scans run high-to-low so the last assignment wins: lowest index.
  always_comb begin
    w_free_row = '0;
    w_hit_idx  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_valid[i])  w_free_row = IDX_W'(i);
      if (w_masked[i])  w_hit_idx  = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    wr_ready_o      = 1'b0;
    srch_ready_o    = 1'b0;
    cam_write_en_o  = '0;
    cam_data_o      = '0;
    cam_search_en_o = 1'b0;
    cam_key_o       = '0;
    w_wr_acc        = 1'b0;
    w_sr_acc        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!clear_i) begin
          wr_ready_o   = !w_full && (!srch_valid_i || r_prio == c_PRIO_WR);
          srch_ready_o = !wr_valid_i || w_full || r_prio == c_PRIO_SR;
        end
        w_wr_acc = wr_valid_i && wr_ready_o;
        w_sr_acc = srch_valid_i && srch_ready_o;
        if (w_wr_acc)      w_state_nxt = WRITE;
        else if (w_sr_acc) w_state_nxt = SEARCH;
      end
      WRITE: begin
        cam_write_en_o = DEPTH'(1) << r_wr_row;
        cam_data_o     = r_wr_data;
        w_state_nxt    = IDLE;
      end
      SEARCH: begin
        cam_search_en_o = 1'b1;
        cam_key_o       = r_key;
        w_state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio      <= c_PRIO_WR;
      r_valid     <= '0;
      r_count     <= '0;
      r_wr_data   <= '0;
      r_wr_row    <= '0;
      r_key       <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_index <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_data <= wr_data_i;
        r_wr_row  <= w_free_row;
        r_prio    <= c_PRIO_SR;
      end
      if (w_sr_acc) begin
        r_key  <= srch_key_i;
        r_prio <= c_PRIO_WR;
      end
      // Clear beats a concurrent write commit; the row stays invalid.
      if (clear_i) begin
        r_valid <= '0;
        r_count <= '0;
      end else if (r_state == WRITE) begin
        r_valid[r_wr_row] <= 1'b1;
        r_count           <= r_count + 1'b1;
      end
      if (r_state == SEARCH) begin
        r_rsp_hit   <= |w_masked;
        r_rsp_index <= w_hit_idx;
      end
    end
  end

`ifdef CAM_CTRL_MULTI_HIT_EN
  logic r_rsp_multi;
  always_ff @(posedge clk) begin
    if (reset)                  r_rsp_multi <= 1'b0;
    else if (r_state == SEARCH) r_rsp_multi <= |(w_masked & (w_masked - 1'b1));
  end
  assign rsp_multi_o = r_rsp_multi;
`else
  assign rsp_multi_o = 1'b0;
`endif

  assign rsp_valid_o = (r_state == RESP);
  assign rsp_hit_o   = r_rsp_hit;
  assign rsp_index_o = r_rsp_index;
  assign count_o     = r_count;
  assign full_o      = w_full;

endmodule
`default_nettype wire

// File: tb/tb_cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cam_ctrl
// Brief   : Directed self-checking bench for cam_ctrl with a behavioural
//           cell array; honours CAM_CTRL_MULTI_HIT_EN for the multi flag.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cam_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid_i = 1'b0, srch_valid_i = 1'b0, rsp_ready_i = 1'b1, clear_i = 1'b0;
  logic [7:0]  wr_data_i = '0, srch_key_i = '0;
  logic        wr_ready_o, srch_ready_o, rsp_valid_o, rsp_hit_o, rsp_multi_o;
  logic [3:0]  rsp_index_o;
  logic [15:0] cam_write_en_o, cam_match_i;
  logic [7:0]  cam_data_o, cam_key_o;
  logic        cam_search_en_o, full_o;
  logic [4:0]  count_o;

  logic [7:0]  mem [16];
  int          n_chk = 0;
  int          n_fail = 0;

`ifdef CAM_CTRL_MULTI_HIT_EN
  localparam logic c_EXP_MULTI = 1'b1;
`else
  localparam logic c_EXP_MULTI = 1'b0;
`endif

  cam_ctrl #(.WIDTH(8), .DEPTH(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .srch_valid_i(srch_valid_i), .srch_ready_o(srch_ready_o), .srch_key_i(srch_key_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
    .rsp_index_o(rsp_index_o), .rsp_multi_o(rsp_multi_o), .clear_i(clear_i),
    .cam_write_en_o(cam_write_en_o), .cam_data_o(cam_data_o),
    .cam_search_en_o(cam_search_en_o), .cam_key_o(cam_key_o),
    .cam_match_i(cam_match_i), .count_o(count_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  // Behavioural cell array: rows keep their contents across clear.
  always @(posedge clk) begin
    for (int r = 0; r < 16; r++)
      if (cam_write_en_o[r]) mem[r] <= cam_data_o;
  end

  always_comb begin
    cam_match_i = '0;
    for (int r = 0; r < 16; r++)
      cam_match_i[r] = cam_search_en_o && (mem[r] == cam_key_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1; wr_valid_i = 1'b0; srch_valid_i = 1'b0; clear_i = 1'b0; rsp_ready_i = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d, input int row);
    logic [15:0] en;
    int k;
    en = 16'h1 << row;
    wr_data_i = d; wr_valid_i = 1'b1; #1;
    k = 0;
    while (!wr_ready_o && k < 20) begin tick(); k++; end
    chk("wr_ready", 32'(wr_ready_o), 32'd1);
    tick();
    wr_valid_i = 1'b0;
    chk("wr_en_row", 32'(cam_write_en_o), 32'(en));
    chk("wr_data", 32'(cam_data_o), 32'(d));
    tick();
  endtask

  task automatic do_search(input logic [7:0] key, input logic hit, input logic [3:0] idx,
                           input logic multi);
    int k;
    srch_key_i = key; srch_valid_i = 1'b1; #1;
    k = 0;
    while (!srch_ready_o && k < 20) begin tick(); k++; end
    chk("srch_ready", 32'(srch_ready_o), 32'd1);
    tick();
    srch_valid_i = 1'b0;
    chk("srch_en", 32'(cam_search_en_o), 32'd1);
    chk("srch_key", 32'(cam_key_o), 32'(key));
    chk("rsp_early", 32'(rsp_valid_o), 32'd0);
    tick();
    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rsp_hit", 32'(rsp_hit_o), 32'(hit));
    chk("rsp_index", 32'(rsp_index_o), 32'(idx));
    chk("rsp_multi", 32'(rsp_multi_o), 32'(multi));
    tick();
    chk("rsp_done", 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int gr [4];
    int g;
    logic rsp_seen, first_hit;

    // Reset state
    reset_dut();
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit_o), 32'd0);
    chk("rst_rsp_index", 32'(rsp_index_o), 32'd0);
    chk("rst_rsp_multi", 32'(rsp_multi_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_wr_en", 32'(cam_write_en_o), 32'd0);
    chk("rst_srch_en", 32'(cam_search_en_o), 32'd0);
    chk("rst_data", 32'(cam_data_o), 32'd0);
    chk("rst_key", 32'(cam_key_o), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready_o), 32'd1);
    chk("rst_srch_ready", 32'(srch_ready_o), 32'd1);

    // Empty search, then two writes and a hit on entry 1
    do_search(8'h77, 1'b0, 4'd0, 1'b0);
    do_write(8'h3C, 0);
    do_write(8'hA5, 1);
    chk("count_two", 32'(count_o), 32'd2);
    do_search(8'hA5, 1'b1, 4'd1, 1'b0);

    // Clear blocks accepts in IDLE
    clear_i = 1'b1; #1;
    chk("clr_wr_ready", 32'(wr_ready_o), 32'd0);
    chk("clr_srch_ready", 32'(srch_ready_o), 32'd0);
    tick();
    clear_i = 1'b0;
    chk("clr_count", 32'(count_o), 32'd0);

    // Duplicate keys report the lowest index
    do_write(8'h11, 0);
    do_write(8'h11, 1);
    do_search(8'h11, 1'b1, 4'd0, c_EXP_MULTI);

    // Clear arriving during WRITE wins
    pulse_clear();
    wr_data_i = 8'h99; wr_valid_i = 1'b1;
    tick();
    wr_valid_i = 1'b0;
    chk("wc_in_write", 32'(cam_write_en_o), 32'h1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("wc_count", 32'(count_o), 32'd0);
    do_search(8'h99, 1'b0, 4'd0, 1'b0);

    // Round-robin from reset with both requesters held
    reset_dut();
    wr_data_i = 8'h50; srch_key_i = 8'h51; wr_valid_i = 1'b1; srch_valid_i = 1'b1;
    g = 0; rsp_seen = 1'b0; first_hit = 1'b1;
    for (int k = 0; k < 40 && g < 4; k++) begin
      tick();
      if (cam_write_en_o != 16'h0) begin
        gr[g] = 0; g++;
        wr_data_i = 8'(wr_data_i + 8'd1);
      end else if (cam_search_en_o) begin
        gr[g] = 1; g++;
      end
      if (rsp_valid_o && !rsp_seen) begin
        rsp_seen = 1'b1; first_hit = rsp_hit_o;
      end
    end
    wr_valid_i = 1'b0; srch_valid_i = 1'b0;
    chk("rr_grants", 32'(g), 32'd4);
    chk("rr_g0_w", 32'(gr[0]), 32'd0);
    chk("rr_g1_s", 32'(gr[1]), 32'd1);
    chk("rr_g2_w", 32'(gr[2]), 32'd0);
    chk("rr_g3_s", 32'(gr[3]), 32'd1);
    chk("rr_first_miss", 32'(first_hit), 32'd0);
    tick();
    chk("rr_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rr_rsp_hit", 32'(rsp_hit_o), 32'd1);
    chk("rr_rsp_index", 32'(rsp_index_o), 32'd1);
    tick();
    chk("rr_count", 32'(count_o), 32'd2);

    // Fill all 16 entries; writes stall, searches proceed
    pulse_clear();
    for (int i = 0; i < 16; i++) do_write(8'(8'h80 + i), i);
    chk("full_count", 32'(count_o), 32'd16);
    chk("full_flag", 32'(full_o), 32'd1);
    wr_valid_i = 1'b1; #1;
    chk("full_wr_ready", 32'(wr_ready_o), 32'd0);
    do_search(8'h8F, 1'b1, 4'd15, 1'b0);
    chk("full_wr_stall", 32'(wr_ready_o), 32'd0);
    chk("full_still", 32'(count_o), 32'd16);
    wr_valid_i = 1'b0;
    pulse_clear();
    chk("fclr_count", 32'(count_o), 32'd0);
    chk("fclr_full", 32'(full_o), 32'd0);
    do_search(8'h8F, 1'b0, 4'd0, 1'b0);

    // Response back-pressure, then reset mid-RESP
    do_write(8'h22, 0);
    srch_key_i = 8'h22; srch_valid_i = 1'b1; rsp_ready_i = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(rsp_valid_o), 32'd1);
      chk("stall_hit", 32'(rsp_hit_o), 32'd1);
      chk("stall_index", 32'(rsp_index_o), 32'd0);
      chk("stall_srch_ready", 32'(srch_ready_o), 32'd0);
      chk("stall_srch_en", 32'(cam_search_en_o), 32'd0);
      tick();
    end
    srch_valid_i = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_hit", 32'(rsp_hit_o), 32'd0);
    reset = 1'b0;
    rsp_ready_i = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_ctrl.md
# cam_ctrl

Sequencing controller for a DEPTH×WIDTH content-addressable memory built from enabled compare flip-flop bit cells. Two requesters share the array: a write port, which allocates the lowest free entry, and a search port, which returns a registered, priority-encoded hit index. The block tracks per-entry valid bits, drives row write enables and the broadcast search key, and qualifies the array's row-match vector with those valid bits. It sits between the lookup/insert clients and the raw cell array.

## Interface
- WIDTH, 8, key/data width in bits
- DEPTH, 16, number of CAM entries (power of two, ≥2)
- IDX_W, 4, index width, must equal log2(DEPTH)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wr_valid_i / wr_ready_o  in/out  1  write request handshake
- wr_data_i  in  WIDTH  data to insert
- srch_valid_i / srch_ready_o  in/out  1  search request handshake
- srch_key_i  in  WIDTH  search key
- rsp_valid_o / rsp_ready_i  out/in  1  search response handshake
- rsp_hit_o  out  1  at least one valid entry matched
- rsp_index_o  out  IDX_W  lowest matching valid index (0 on miss)
- rsp_multi_o  out  1  more than one valid entry matched
- clear_i  in  1  invalidate all entries
- cam_write_en_o  out  DEPTH  one-hot row write enable to the array
- cam_data_o  out  WIDTH  write data to the array
- cam_search_en_o  out  1  search enable broadcast to all cells
- cam_key_o  out  WIDTH  search key broadcast
- cam_match_i  in  DEPTH  per-row match from the array (AND of bit matches, combinational)
- count_o  out  IDX_W+1  number of valid entries
- full_o  out  1  count_o == DEPTH

## Operation
- FSM states: IDLE, WRITE, SEARCH, RESP.
- In IDLE, a request is accepted on valid&&ready. Readiness is asserted only in IDLE with clear_i low:
  - wr_ready_o = !full_o && (!srch_valid_i || prio==WR).
  - srch_ready_o = (!wr_valid_i || full_o || prio==SR).
- Arbitration is round-robin. The prio flag toggles away from the granted port on each accept. Reset sets prio=WR.
- Write accept: latch wr_data_i and the lowest-index invalid entry; go to WRITE.
- WRITE, one cycle: cam_write_en_o is one-hot on the latched row and cam_data_o carries the latched data. The valid bit is set and count_o increments at the end of the cycle. Next state is IDLE.
- Search accept: latch srch_key_i; go to SEARCH.
- SEARCH, one cycle: cam_search_en_o=1 and cam_key_o carries the key. At the end of the cycle, register cam_match_i & valid into the hit, index and multi flags. Next state is RESP.
- RESP: hold rsp_valid_o=1 and the result stable until rsp_ready_i, then go to IDLE.
- Outside WRITE and SEARCH, cam_write_en_o=0, cam_search_en_o=0, cam_data_o=0 and cam_key_o=0.
- clear_i: valid bitmap and count_o go to 0 at the next edge, in any state.
  - In IDLE, clear_i blocks accepts that cycle.
  - In WRITE, clear wins and the entry is left invalid.
  - In SEARCH, the registered match is qualified with pre-clear valid bits.
  - In RESP, the pending response is unaffected.
  - Array contents are not erased.
- Duplicate keys are permitted. Search reports the lowest index.

## Timing
- Reset values:
  - state IDLE; prio WR; valid bitmap 0.
  - rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_multi_o all 0.
  - count_o 0, full_o 0; all cam_* outputs 0.
- Reset mid-operation: an in-flight write or response is dropped.
- Search latency: accept at cycle N, SEARCH at N+1, rsp_valid_o first high at N+2.
- Write: accept at N, cam_write_en_o at N+1. The entry is visible to a search accepted at N+2 or later.
- Throughput: one write per 2 cycles; one search per 3 cycles with rsp_ready_i tied high.
- When full_o=1, writes stall (wr_ready_o=0) and searches proceed.

## Configuration
- CAM_CTRL_MULTI_HIT_EN defined: rsp_multi_o is registered in SEARCH. It is 1 when two or more valid rows match.
- CAM_CTRL_MULTI_HIT_EN undefined: rsp_multi_o is tied to 0 and no population-count logic is built. All other behaviour is identical.

## Test plan
- Reset, then write 0x3C and 0xA5 → entries 0 and 1 valid, count_o=2. Search 0xA5 → rsp_hit_o=1, rsp_index_o=1, two cycles after accept.
- Search 0x77 on an empty CAM → rsp_hit_o=0, rsp_index_o=0, rsp_multi_o=0.
- wr_valid_i and srch_valid_i held high together from reset → grants alternate W, S, W, S; no request is lost.
- Fill 16 entries → full_o=1 and wr_ready_o=0 while searches still complete. Then pulse clear_i → count_o=0, and search of the last-written key misses.
- Write 0x11 twice (entries 0 and 1), then search 0x11 → index 0. rsp_multi_o=1 with the macro defined, 0 without.
- Hold rsp_ready_i low for 5 cycles in RESP → response stays stable, srch_ready_o=0 and no cam_search_en_o pulse. Assert reset mid-RESP → rsp_valid_o=0 next cycle and count_o=0.
